// File: rtl/ladybird_config.sv
// Shared configuration for the ladybird memory-side blocks.
// Holds the bus width and the arbiter state encoding.
package ladybird_config;

    localparam int XLEN = 32;
    localparam int SLEN = XLEN / 8;

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } arb_state_t;

endpackage

// File: rtl/ladybird_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant plus a flag telling whether anything was found.
module ladybird_rr_pick
    import ladybird_config::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            valid
);

    // Walk NREQ slots starting at ptr and stop at the first request.
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// N-way round-robin arbiter onto a single memory port.
// Writes are posted; at most one read is outstanding at a time.
module ladybird_bus_arbiter
    import ladybird_config::*;
#(
    parameter int NREQ = 2
) (
    input  logic                       clk,
    input  logic                       anrst,
    input  logic                       nrst,
    input  logic [NREQ-1:0]            r_valid,
    output logic [NREQ-1:0]            r_ready,
    input  logic [NREQ-1:0][XLEN-1:0]  r_addr,
    input  logic [NREQ-1:0][XLEN-1:0]  r_data,
    input  logic [NREQ-1:0][SLEN-1:0]  r_wstrb,
    output logic [NREQ-1:0]            r_rvalid,
    input  logic [NREQ-1:0]            r_rready,
    output logic [XLEN-1:0]            r_rdata,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [XLEN-1:0]            m_addr,
    output logic [XLEN-1:0]            m_data,
    output logic [SLEN-1:0]            m_wstrb,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    input  logic [XLEN-1:0]            m_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic            lock, lock_d;
    logic [PW-1:0]   lock_g, lock_g_d;
    logic [PW-1:0]   owner, owner_d;

    logic [NREQ-1:0] pick_oh;
    logic            pick_v;
    logic [PW-1:0]   pick_idx;
    logic            lock_hit;
    logic [PW-1:0]   g;
    logic            any;
    logic            run;

    ladybird_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (r_valid),
        .ptr   (ptr),
        .grant (pick_oh),
        .valid (pick_v)
    );

    // Encode the picker's one-hot grant and apply the grant lock.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
        lock_hit = lock && r_valid[lock_g];
        g        = lock_hit ? lock_g : pick_idx;
        any      = lock_hit || pick_v;
        run      = anrst && nrst;
    end

    // Arbiter registers; async or soft reset returns everything to idle.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state  <= IDLE;
            ptr    <= '0;
            lock   <= 1'b0;
            lock_g <= '0;
            owner  <= '0;
        end else if (!nrst) begin
            state  <= IDLE;
            ptr    <= '0;
            lock   <= 1'b0;
            lock_g <= '0;
            owner  <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            lock   <= lock_d;
            lock_g <= lock_g_d;
            owner  <= owner_d;
        end
    end

    // Next-state and handshake outputs for the grant and response phases.
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        lock_d   = lock;
        lock_g_d = lock_g;
        owner_d  = owner;
        m_valid  = 1'b0;
        m_rready = 1'b0;
        r_ready  = '0;
        r_rvalid = '0;
        m_addr   = r_addr[g];
        m_data   = r_data[g];
        m_wstrb  = r_wstrb[g];
        r_rdata  = m_rdata;
        case (state)
            IDLE: begin
                if (run && any) begin
                    m_valid    = 1'b1;
                    r_ready[g] = m_ready;
                    if (m_ready) begin
                        ptr_d  = (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
                        lock_d = 1'b0;
                        if (r_wstrb[g] == '0) begin
                            owner_d = g;
                            state_d = WAIT_RESP;
                        end
                    end else begin
                        lock_d   = 1'b1;
                        lock_g_d = g;
                    end
                end else begin
                    lock_d = 1'b0;
                end
            end
            WAIT_RESP: begin
                if (run) begin
                    r_rvalid[owner] = m_rvalid;
                    m_rready        = r_rready[owner];
                    if (m_rvalid && r_rready[owner]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for the two-requester arbiter configuration.
// Each step drives inputs after a rising edge and checks at the falling edge.
module tb_ladybird_bus_arbiter;
    import ladybird_config::*;

    localparam int N = 2;

    logic                    clk;
    logic                    anrst;
    logic                    nrst;
    logic [N-1:0]            r_valid;
    logic [N-1:0]            r_ready;
    logic [N-1:0][XLEN-1:0]  r_addr;
    logic [N-1:0][XLEN-1:0]  r_data;
    logic [N-1:0][SLEN-1:0]  r_wstrb;
    logic [N-1:0]            r_rvalid;
    logic [N-1:0]            r_rready;
    logic [XLEN-1:0]         r_rdata;
    logic                    m_valid;
    logic                    m_ready;
    logic [XLEN-1:0]         m_addr;
    logic [XLEN-1:0]         m_data;
    logic [SLEN-1:0]         m_wstrb;
    logic                    m_rvalid;
    logic                    m_rready;
    logic [XLEN-1:0]         m_rdata;

    int total = 0;
    int bad   = 0;

    ladybird_bus_arbiter #(.NREQ(N)) dut (
        .clk      (clk),
        .anrst    (anrst),
        .nrst     (nrst),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .r_wstrb  (r_wstrb),
        .r_rvalid (r_rvalid),
        .r_rready (r_rready),
        .r_rdata  (r_rdata),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_wstrb  (m_wstrb),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        anrst    = 1'b0;
        nrst     = 1'b1;
        r_valid  = 2'b11;
        r_addr   = '0;
        r_data   = '0;
        r_wstrb  = '0;
        r_rready = '0;
        m_ready  = 1'b1;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_r_ready", 32'(r_ready), 32'd0);
        chk("rst_m_rready", 32'(m_rready), 32'd0);
        chk("rst_r_rvalid", 32'(r_rvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1 anrst = 1'b1;

        // two reads, round robin 0 then 1
        r_addr[0] = 32'h10;
        r_addr[1] = 32'h20;
        r_data[0] = 32'h1111;
        @(negedge clk);
        chk("rr_g0_valid", 32'(m_valid), 32'd1);
        chk("rr_g0_addr", m_addr, 32'h10);
        chk("rr_g0_data", m_data, 32'h1111);
        chk("rr_g0_ready", 32'(r_ready), 32'd1);
        cyc();
        r_valid = 2'b10;
        @(negedge clk);
        chk("rr_wait_no_mvalid", 32'(m_valid), 32'd0);
        chk("rr_wait_no_ready", 32'(r_ready), 32'd0);
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 32'hAAAA0001;
        r_rready = 2'b11;
        @(negedge clk);
        chk("rr_resp0_rvalid", 32'(r_rvalid), 32'd1);
        chk("rr_resp0_mrready", 32'(m_rready), 32'd1);
        chk("rr_resp0_rdata", r_rdata, 32'hAAAA0001);
        chk("rr_resp0_no_mvalid", 32'(m_valid), 32'd0);
        cyc();
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("rr_g1_addr", m_addr, 32'h20);
        chk("rr_g1_ready", 32'(r_ready), 32'd2);
        cyc();
        r_valid = 2'b00;
        @(negedge clk);
        chk("rr_wait1_no_mvalid", 32'(m_valid), 32'd0);
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 32'hAAAA0002;
        @(negedge clk);
        chk("rr_resp1_rvalid", 32'(r_rvalid), 32'd2);
        cyc();
        m_rvalid = 1'b0;
        r_rready = 2'b00;
        r_valid  = 2'b11;
        m_ready  = 1'b0;
        @(negedge clk);
        chk("rr_ptr_back_0", m_addr, 32'h10);
        chk("rr_unaccepted_ready", 32'(r_ready), 32'd0);
        cyc();
        r_valid = 2'b00;
        m_ready = 1'b1;

        // grant lock while memory stalls a write
        cyc();
        r_valid    = 2'b10;
        r_addr[1]  = 32'h30;
        r_wstrb[1] = 4'hF;
        r_addr[0]  = 32'h40;
        r_wstrb[0] = 4'hF;
        m_ready    = 1'b0;
        @(negedge clk);
        chk("lock_c0_addr", m_addr, 32'h30);
        chk("lock_c0_wstrb", 32'(m_wstrb), 32'hF);
        cyc();
        r_valid = 2'b11;
        @(negedge clk);
        chk("lock_c1_addr", m_addr, 32'h30);
        cyc();
        @(negedge clk);
        chk("lock_c2_addr", m_addr, 32'h30);
        cyc();
        m_ready = 1'b1;
        @(negedge clk);
        chk("lock_acc_addr", m_addr, 32'h30);
        chk("lock_acc_ready", 32'(r_ready), 32'd2);
        cyc();
        r_valid = 2'b01;
        @(negedge clk);
        chk("lock_next_valid", 32'(m_valid), 32'd1);
        chk("lock_next_addr", m_addr, 32'h40);
        chk("lock_next_ready", 32'(r_ready), 32'd1);
        cyc();
        r_valid = 2'b00;

        // locked requester withdraws: arbitration restarts at once
        cyc();
        r_addr[0] = 32'h44;
        r_valid   = 2'b11;
        m_ready   = 1'b0;
        @(negedge clk);
        chk("drop_pick1", m_addr, 32'h30);
        cyc();
        r_valid = 2'b01;
        @(negedge clk);
        chk("drop_regrant_valid", 32'(m_valid), 32'd1);
        chk("drop_regrant_addr", m_addr, 32'h44);
        cyc();
        r_valid = 2'b00;
        m_ready = 1'b1;

        // four back-to-back writes from requester 0
        for (int k = 0; k < 4; k++) begin
            cyc();
            r_valid    = 2'b01;
            r_addr[0]  = 32'h50 + 32'(4 * k);
            r_wstrb[0] = 4'hF;
            @(negedge clk);
            chk("b2b_valid", 32'(m_valid), 32'd1);
            chk("b2b_ready", 32'(r_ready), 32'd1);
            chk("b2b_addr", m_addr, 32'h50 + 32'(4 * k));
        end

        // read with a stalled response consumer
        cyc();
        r_addr[0]  = 32'h100;
        r_wstrb[0] = 4'h0;
        @(negedge clk);
        chk("rd_addr", m_addr, 32'h100);
        chk("rd_ready", 32'(r_ready), 32'd1);
        cyc();
        r_valid    = 2'b10;
        r_addr[1]  = 32'h60;
        r_wstrb[1] = 4'hF;
        m_rvalid   = 1'b1;
        m_rdata    = 32'hDEADBEEF;
        r_rready   = 2'b00;
        @(negedge clk);
        chk("rd_hold0_rvalid", 32'(r_rvalid), 32'd1);
        chk("rd_hold0_mrready", 32'(m_rready), 32'd0);
        chk("rd_hold0_rdata", r_rdata, 32'hDEADBEEF);
        chk("rd_hold0_no_mvalid", 32'(m_valid), 32'd0);
        chk("rd_hold0_no_ready", 32'(r_ready), 32'd0);
        cyc();
        @(negedge clk);
        chk("rd_hold1_rvalid", 32'(r_rvalid), 32'd1);
        chk("rd_hold1_mrready", 32'(m_rready), 32'd0);
        chk("rd_hold1_no_mvalid", 32'(m_valid), 32'd0);
        cyc();
        r_rready = 2'b01;
        @(negedge clk);
        chk("rd_take_mrready", 32'(m_rready), 32'd1);
        chk("rd_take_rvalid", 32'(r_rvalid), 32'd1);
        cyc();
        m_rvalid = 1'b0;
        r_rready = 2'b00;
        @(negedge clk);
        chk("rd_idle_valid", 32'(m_valid), 32'd1);
        chk("rd_idle_addr", m_addr, 32'h60);
        cyc();
        r_valid = 2'b00;

        // async reset during an outstanding read
        cyc();
        r_valid    = 2'b01;
        r_addr[0]  = 32'h200;
        r_wstrb[0] = 4'h0;
        @(negedge clk);
        chk("ar_read_ready", 32'(r_ready), 32'd1);
        cyc();
        r_valid  = 2'b00;
        m_rvalid = 1'b1;
        m_rdata  = 32'h55;
        r_rready = 2'b11;
        @(negedge clk);
        chk("ar_wait_rvalid", 32'(r_rvalid), 32'd1);
        #1 anrst = 1'b0;
        #1;
        chk("ar_now_rvalid", 32'(r_rvalid), 32'd0);
        chk("ar_now_mrready", 32'(m_rready), 32'd0);
        chk("ar_now_mvalid", 32'(m_valid), 32'd0);
        cyc();
        anrst = 1'b1;
        @(negedge clk);
        chk("ar_stray_rvalid", 32'(r_rvalid), 32'd0);
        chk("ar_stray_mrready", 32'(m_rready), 32'd0);
        cyc();
        m_rvalid = 1'b0;
        r_rready = 2'b00;

        // soft reset during an outstanding read
        cyc();
        r_valid   = 2'b01;
        r_addr[0] = 32'h300;
        @(negedge clk);
        chk("sr_read_ready", 32'(r_ready), 32'd1);
        cyc();
        r_valid  = 2'b00;
        nrst     = 1'b0;
        m_rvalid = 1'b1;
        r_rready = 2'b01;
        @(negedge clk);
        chk("sr_gated_mrready", 32'(m_rready), 32'd0);
        chk("sr_gated_rvalid", 32'(r_rvalid), 32'd0);
        cyc();
        nrst      = 1'b1;
        r_valid   = 2'b11;
        r_addr[1] = 32'h304;
        m_ready   = 1'b0;
        @(negedge clk);
        chk("sr_stray_mrready", 32'(m_rready), 32'd0);
        chk("sr_ptr_zero", m_addr, 32'h300);
        cyc();
        r_valid  = 2'b00;
        m_rvalid = 1'b0;
        r_rready = 2'b00;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
